// File: rtl/key_debounce_pulse_pkg.sv
// Shared types and defaults for the flap-key conditioner.
// State encodings, 50 MHz timing defaults, sizing helper.
package key_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned DEF_DEBOUNCE = 1_000_000;
  localparam int unsigned DEF_RPT_DLY  = 25_000_000;
  localparam int unsigned DEF_RPT_PER  = 10_000_000;
  localparam int unsigned DEF_CNT_W    = 8;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input.
// Reset value is a parameter so an idle key reads as released.
module key_debounce_pulse_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Shift the raw input through two flops.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// Flap-key conditioner: sync, debounce, press pulse,
// optional hold auto-repeat and a wrapping pulse counter.
module key_debounce_pulse
  import key_debounce_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int unsigned REPEAT_DELAY    = DEF_RPT_DLY,
  parameter int unsigned REPEAT_PERIOD   = DEF_RPT_PER,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iKEY_N,
  input  logic             iREPEAT_EN,
  input  logic             iCLR_CNT,
  output logic             oLEVEL,
  output logic             oPULSE,
  output logic [CNT_W-1:0] oCOUNT
);

  localparam int unsigned TMAX =
    max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned TW =
    (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] DB_LAST = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

  logic             key_n_s;
  logic             key_p;
  key_state_e       state_q;
  logic [TW-1:0]    db_q;
  logic [TW-1:0]    rp_q;
  logic             first_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  key_debounce_pulse_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .iCLK (iCLK),
    .iRST (iRST),
    .d_i  (iKEY_N),
    .q_o  (key_n_s)
  );

  assign key_p = ~key_n_s;

  // Debounce FSM with repeat timer, pulse and counter.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= IDLE;
      db_q    <= '0;
      rp_q    <= '0;
      first_q <= 1'b1;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (key_p) begin
            state_q <= PRESS_WAIT;
            db_q    <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_p) begin
            state_q <= IDLE;
          end else if (db_q == DB_LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            pulse_q <= 1'b1;
            cnt_q   <= cnt_q + 1'b1;
            rp_q    <= '0;
            first_q <= 1'b1;
          end else begin
            db_q <= db_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!key_p) begin
            state_q <= RELEASE_WAIT;
            db_q    <= '0;
          end else if (iREPEAT_EN) begin
            if (rp_q == (first_q ? RD_LAST : RP_LAST)) begin
              pulse_q <= 1'b1;
              cnt_q   <= cnt_q + 1'b1;
              rp_q    <= '0;
              first_q <= 1'b0;
            end else begin
              rp_q <= rp_q + 1'b1;
            end
          end else begin
            rp_q    <= '0;
            first_q <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (key_p) begin
            state_q <= PRESSED;
          end else if (db_q == DB_LAST) begin
            state_q <= IDLE;
            level_q <= 1'b0;
          end else begin
            db_q <= db_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (iCLR_CNT) cnt_q <= '0;
    end
  end

  assign oLEVEL = level_q;
  assign oPULSE = pulse_q;
  assign oCOUNT = cnt_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: vector table, corner
// sequences and random stimulus against a reference model.
module tb_key_debounce_pulse;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          key_n;
  logic          rep_en;
  logic          clr;
  logic          lvl;
  logic          pls;
  logic [CW-1:0] cnt;

  int n_chk;
  int n_pass;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (CW)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst_n),
    .iKEY_N     (key_n),
    .iREPEAT_EN (rep_en),
    .iCLR_CNT   (clr),
    .oLEVEL     (lvl),
    .oPULSE     (pls),
    .oCOUNT     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the key is seen two samples late;
  // the level flips after D+1 consecutive samples that
  // disagree with it; repeats count steady held samples.
  logic          m_pipe[2];
  logic          m_level;
  int            m_run;
  int            m_held;
  logic          m_first;
  logic          m_pulse;
  logic [CW-1:0] m_cnt;

  task automatic model_reset();
    m_pipe[0] = 1'b1;
    m_pipe[1] = 1'b1;
    m_level   = 1'b0;
    m_run     = 0;
    m_held    = 0;
    m_first   = 1'b1;
    m_pulse   = 1'b0;
    m_cnt     = '0;
  endtask

  task automatic model_edge(
    input logic kn,
    input logic r,
    input logic c
  );
    logic k;
    int   tgt;
    k         = ~m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = kn;
    m_pulse   = 1'b0;
    if (!m_level) begin
      m_run = k ? m_run + 1 : 0;
      if (m_run == D + 1) begin
        m_level = 1'b1;
        m_run   = 0;
        m_pulse = 1'b1;
        m_held  = 0;
        m_first = 1'b1;
      end
    end else if (m_run == 0 && k) begin
      if (r) begin
        m_held = m_held + 1;
        tgt    = m_first ? RD : RP;
        if (m_held == tgt) begin
          m_pulse = 1'b1;
          m_held  = 0;
          m_first = 1'b0;
        end
      end else begin
        m_held  = 0;
        m_first = 1'b1;
      end
    end else begin
      m_run = !k ? m_run + 1 : 0;
      if (m_run == D + 1) begin
        m_level = 1'b0;
        m_run   = 0;
      end
    end
    if (c) m_cnt = '0;
    else if (m_pulse) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
  endtask

  task automatic step(input logic k, input logic r, input logic c);
    key_n  = k;
    rep_en = r;
    clr    = c;
    @(posedge clk);
    model_edge(k, r, c);
    #1;
  endtask

  task automatic do_reset();
    key_n  = 1'b1;
    rep_en = 1'b0;
    clr    = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic          kn;
    logic          rep;
    logic          clr;
    logic          lvl;
    logic          pls;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic kcur;
    logic rcur;
    int   left;
    n_chk  = 0;
    n_pass = 0;
    model_reset();

    for (int i = 0; i < 12; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0,
                 (i >= 6), (i == 6), CW'(i >= 6)};
    for (int i = 12; i < 20; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0,
                 (i < 18), 1'b0, CW'(1)};

    // reset state
    key_n  = 1'b1;
    rep_en = 1'b0;
    clr    = 1'b0;
    rst_n  = 1'b0;
    #12;
    chk("rst_level", lvl, 0);
    chk("rst_pulse", pls, 0);
    chk("rst_count", cnt, 0);
    do_reset();

    // clean press then release, table driven
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].kn, tbl[i].rep, tbl[i].clr);
      chk($sformatf("tbl_lvl[%0d]", i), lvl, tbl[i].lvl);
      chk($sformatf("tbl_pls[%0d]", i), pls, tbl[i].pls);
      chk($sformatf("tbl_cnt[%0d]", i), cnt, tbl[i].cnt);
    end

    // glitchy press: low 2, high 1, repeated
    do_reset();
    for (int g = 0; g < 6; g++) begin
      for (int j = 0; j < 3; j++) begin
        step((j == 2), 1'b0, 1'b0);
        chk($sformatf("glitch_pls[%0d]", g), pls, 0);
        chk($sformatf("glitch_lvl[%0d]", g), lvl, 0);
      end
    end
    chk("glitch_cnt", cnt, 0);

    // held key with auto-repeat
    do_reset();
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("rep_pls[%0d]", i), pls,
          (i == 6 || i == 16 || i == 19 || i == 22));
      chk($sformatf("rep_cnt[%0d]", i), cnt,
          (i >= 22) ? 4 : (i >= 19) ? 3 :
          (i >= 16) ? 2 : (i >= 6) ? 1 : 0);
    end

    // counter wrap after 16 presses, then clear on pulse
    do_reset();
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b0, 1'b0);
        if (i == 6)
          chk($sformatf("wrap_pls[%0d]", p), pls, 1);
      end
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    end
    chk("wrap_cnt", cnt, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, (i == 6));
      if (i == 6) begin
        chk("clr_pls", pls, 1);
        chk("clr_cnt", cnt, 0);
      end
    end
    chk("clr_cnt_after", cnt, 0);

    // release bounce keeps the key pressed
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    chk("bnc_cnt0", cnt, 1);
    for (int i = 0; i < 13; i++) begin
      step((i < 2), 1'b0, 1'b0);
      chk($sformatf("bnc_lvl[%0d]", i), lvl, 1);
      chk($sformatf("bnc_pls[%0d]", i), pls, 0);
    end
    chk("bnc_cnt1", cnt, 1);

    // reset while pressed, key still held afterwards
    rst_n = 1'b0;
    #2;
    chk("mid_rst_lvl", lvl, 0);
    chk("mid_rst_pls", pls, 0);
    chk("mid_rst_cnt", cnt, 0);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("mid_pls[%0d]", i), pls, (i == 6));
      chk($sformatf("mid_lvl[%0d]", i), lvl, (i >= 6));
      chk($sformatf("mid_cnt[%0d]", i), cnt, (i >= 6));
    end

    // random stimulus against the model
    do_reset();
    kcur = 1'b1;
    rcur = 1'b0;
    left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        kcur = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) left = $urandom_range(15, 40);
        else left = $urandom_range(1, 8);
      end
      left--;
      if ($urandom_range(0, 59) == 0) rcur = ~rcur;
      step(kcur, rcur, ($urandom_range(0, 79) == 0));
      chk($sformatf("rnd_lvl[%0d]", i), lvl, m_level);
      chk($sformatf("rnd_pls[%0d]", i), pls, m_pulse);
      chk($sformatf("rnd_cnt[%0d]", i), cnt, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
